// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, one-outstanding imem request port,
// and a small response FIFO whose head feeds the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   held_addr;
    logic          outstanding;
    logic          kill;
    logic          kill_next;
    logic          held;
    logic          held_stale;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic grant;
    logic resp;
    logic push;
    logic pop;
    logic do_pop;
    logic credit_ok;

    assign if_valid = (count != '0);
    assign if_inst  = if_valid ? fifo_inst[rd_ptr] : NOP;
    assign if_pc    = if_valid ? fifo_pc[rd_ptr] : 32'h0;

    // Credit counts FIFO entries plus the in-flight word, less the head leaving now.
    assign pop       = if_valid && !stall;
    assign credit_ok = (32'(count) + 32'(outstanding)) < (32'(DEPTH) + 32'(pop));

    assign imem_req  = !rst_i && (held || ((!outstanding || imem_rvalid) && credit_ok));
    assign imem_addr = held ? held_addr : fetch_pc;

    assign grant  = imem_req && imem_gnt;
    assign resp   = imem_rvalid && outstanding;
    assign push   = resp && !kill && !redirect_valid;
    assign do_pop = pop && !redirect_valid;

    // A held request that a redirect overtook, or a request granted in the
    // redirect cycle itself, returns a word from the wrong path.
    always_comb begin
        kill_next = kill;
        if (resp && kill) begin
            kill_next = 1'b0;
        end
        if (redirect_valid && outstanding && !imem_rvalid) begin
            kill_next = 1'b1;
        end
        if (grant && (redirect_valid || held_stale)) begin
            kill_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= 32'h0;
            held_addr   <= 32'h0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            held        <= 1'b0;
            held_stale  <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            kill       <= kill_next;
            held       <= imem_req && !imem_gnt;
            held_addr  <= imem_addr;
            held_stale <= imem_req && !imem_gnt && (held_stale || redirect_valid);

            if (grant) begin
                outstanding <= 1'b1;
                req_pc      <= imem_addr;
            end else if (resp) begin
                outstanding <= 1'b0;
            end

            // A stale grant must not overwrite the redirect target already in fetch_pc.
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
            end else if (grant && !held_stale) begin
                fetch_pc <= imem_addr + 32'd4;
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(do_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !do_pop && count == CW'(DEPTH)));
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for reset and
// PC wrap, and a randomized run against a program-order reference model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_valid(w_valid), .if_inst(w_inst), .if_pc(w_pc)
    );

    // Memory model for the main instance: latency 1..3 cycles, one in flight.
    int          lat = 1;
    logic        resp_pending = 1'b0;
    logic [1:0]  resp_wait = 2'd0;
    logic [31:0] resp_addr = 32'h0;

    assign imem_rvalid = resp_pending && (resp_wait == 2'd0);
    assign imem_rdata  = inst_of(resp_addr);

    always @(posedge clk_i) begin
        if (imem_req && imem_gnt) begin
            checks++;
            if (resp_pending && !imem_rvalid) begin
                errors++;
                $display("FAIL second_outstanding: grant at %08h while a fetch is still in flight", imem_addr);
            end
            resp_pending <= 1'b1;
            resp_wait    <= 2'(lat - 1);
            resp_addr    <= imem_addr;
        end else if (imem_rvalid) begin
            resp_pending <= 1'b0;
        end else if (resp_pending) begin
            resp_wait <= resp_wait - 2'd1;
        end
    end

    // Always-grant, 1-cycle memory for the wrap instance.
    always @(posedge clk_i) begin
        w_rvalid <= w_req;
        w_rdata  <= inst_of(w_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic rd,
                        input logic [31:0] rp, input logic g);
        @(negedge clk_i);
        rst_i = rs;
        stall = st;
        redirect_valid = rd;
        redirect_pc = rp;
        imem_gnt = g;
        #1;
    endtask

    typedef struct {
        logic        rs;
        logic        ck;
        logic        st;
        logic        rd;
        logic [31:0] rp;
        logic        g;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rs, input logic ck, input logic st, input logic rd,
                       input logic [31:0] rp, input logic g, input logic ev,
                       input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.rs = rs; v.ck = ck; v.st = st; v.rd = rd; v.rp = rp; v.g = g;
        v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic rows_reset_and_start();
        row(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        row(0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h4);
        row(0, 1, 0, 0, 0, 1, 1, 32'h0, 1, 32'h8);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic        prev_redir;
        int          consumed;
        logic        s;
        logic        r;
        logic        g;
        logic [31:0] rp;
        logic [31:0] e;

        // Stream, then 5-cycle stall and release.
        rows_reset_and_start();
        row(0, 1, 0, 0, 0, 1, 1, 32'h4, 1, 32'hC);
        for (int i = 0; i < 5; i++) row(0, 1, 1, 0, 0, 1, 1, 32'h8, 0, 0);
        row(0, 1, 0, 0, 0, 1, 1, 32'h8,  1, 32'h10);
        row(0, 1, 0, 0, 0, 1, 1, 32'hC,  1, 32'h14);
        row(0, 1, 0, 0, 0, 1, 1, 32'h10, 1, 32'h18);
        row(0, 1, 0, 0, 0, 1, 1, 32'h14, 1, 32'h1C);
        // Redirect in the cycle the response for 0x8 returns.
        rows_reset_and_start();
        row(0, 1, 0, 1, 32'h102, 1, 1, 32'h4, 1, 32'hC);
        row(0, 1, 0, 0, 0, 1, 0, 0,        1, 32'h100);
        row(0, 1, 0, 0, 0, 1, 0, 0,        1, 32'h104);
        row(0, 1, 0, 0, 0, 1, 1, 32'h100,  1, 32'h108);
        row(0, 1, 0, 0, 0, 1, 1, 32'h104,  1, 32'h10C);
        // Grant withheld at 0xC with a redirect to 0x200 during the wait.
        rows_reset_and_start();
        row(0, 1, 0, 0, 0,        0, 1, 32'h4, 1, 32'hC);
        row(0, 1, 0, 1, 32'h200,  0, 1, 32'h8, 1, 32'hC);
        row(0, 1, 0, 0, 0,        0, 0, 0,     1, 32'hC);
        row(0, 1, 0, 0, 0,        1, 0, 0,     1, 32'hC);
        row(0, 1, 0, 0, 0,        1, 0, 0,     1, 32'h200);
        row(0, 1, 0, 0, 0,        1, 0, 0,     1, 32'h204);
        row(0, 1, 0, 0, 0,        1, 1, 32'h200, 1, 32'h208);

        foreach (vecs[i]) begin
            step(vecs[i].rs, vecs[i].st, vecs[i].rd, vecs[i].rp, vecs[i].g);
            if (vecs[i].ck) begin
                chk($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(vecs[i].ev));
                chk($sformatf("row%0d if_pc", i), if_pc, vecs[i].epc);
                chk($sformatf("row%0d if_inst", i), if_inst,
                    vecs[i].ev ? inst_of(vecs[i].epc) : NOP);
                chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].ereq));
                if (vecs[i].ereq) chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            end
        end

        // Wrap instance: PC sequence FFFF_FFF8, FFFF_FFFC, 0.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("wrap reset if_valid", 32'(w_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("wrap addr c0", w_addr, 32'hFFFF_FFF8);
        step(0, 0, 0, 0, 1);
        chk("wrap addr c1", w_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("wrap addr c2", w_addr, 32'h0000_0000);
        chk("wrap pc c2", w_pc, 32'hFFFF_FFF8);
        chk("wrap inst c2", w_inst, inst_of(32'hFFFF_FFF8));
        step(0, 0, 0, 0, 1);
        chk("wrap pc c3", w_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("wrap pc c4", w_pc, 32'h0000_0000);
        chk("wrap inst c4", w_inst, inst_of(32'h0000_0000));

        // Reset with a fetch in flight; its late response must be ignored.
        lat = 3;
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rstmid c0 req", 32'(imem_req), 32'h1);
        step(1, 0, 0, 0, 1);
        chk("rstmid req during reset", 32'(imem_req), 32'h0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rstmid late rvalid seen", 32'(imem_rvalid), 32'h1);
        chk("rstmid restart req", 32'(imem_req), 32'h1);
        chk("rstmid restart addr", imem_addr, 32'h0);
        chk("rstmid valid c3", 32'(if_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("rstmid valid c4", 32'(if_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rstmid valid c6", 32'(if_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("rstmid valid c7", 32'(if_valid), 32'h1);
        chk("rstmid pc c7", if_pc, 32'h0);
        lat = 1;

        // Randomized run: consumed PCs must follow program order with redirects.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        exp_q.delete();
        exp_q.push_back(32'h0);
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        prev_redir = 1'b0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            s  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 39) == 0);
            g  = ($urandom_range(0, 3) != 0);
            rp = $urandom & 32'h0000_0FFF;
            lat = $urandom_range(1, 3);
            step(0, s, r, rp, g);
            if (prev_hold) begin
                chk("rand held req", 32'(imem_req), 32'h1);
                chk("rand held addr", imem_addr, prev_addr);
            end
            if (prev_redir) chk("rand flush", 32'(if_valid), 32'h0);
            if (if_valid) chk("rand inst", if_inst, inst_of(if_pc));
            else begin
                chk("rand idle inst", if_inst, NOP);
                chk("rand idle pc", if_pc, 32'h0);
            end
            if (r) begin
                exp_q.delete();
                exp_q.push_back(rp & ~32'h3);
            end else if (if_valid && !s) begin
                e = exp_q.pop_front();
                chk("rand order pc", if_pc, e);
                exp_q.push_back(e + 32'd4);
                consumed++;
            end
            prev_hold = imem_req && !imem_gnt;
            prev_addr = imem_addr;
            prev_redir = r;
        end
        chk("rand progress", 32'(consumed > 500), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
